// File: rtl/md_pkg.sv
// md_pkg: shared state encoding and default record widths/depth for the particle I/O sequencer.
package md_pkg;
    localparam int MD_IN_W  = 256;
    localparam int MD_OUT_W = 192;
    localparam int MD_DEPTH = 300;
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_STREAM = 3'd1,
        S_WAIT   = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_t;
endpackage

// File: rtl/md_sdp_ram.sv
// md_sdp_ram: simple dual-port RAM, one write port, registered read; out-of-range reads return 0.
module md_sdp_ram #(
    parameter int W  = 8,
    parameter int D  = 16,
    parameter int AW = $clog2(D + 1)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);
    logic [W-1:0] mem_q [D];

    always_ff @(posedge clk_i) begin
        if (we_i && waddr_i < AW'(D)) mem_q[waddr_i] <= wdata_i;
        rdata_o <= (raddr_i < AW'(D)) ? mem_q[raddr_i] : '0;
    end
endmodule

// File: rtl/particle_io_sequencer.sv
// particle_io_sequencer: loads particle records, streams them into an MD core,
// waits for completion, then drains per-particle results into a readback buffer.
module particle_io_sequencer
    import md_pkg::*;
#(
    parameter int IN_W    = MD_IN_W,
    parameter int OUT_W   = MD_OUT_W,
    parameter int DEPTH   = MD_DEPTH,
    parameter int WR_GAP  = 4,
    parameter int TIMEOUT = 65536,
    parameter int CW      = $clog2(DEPTH + 1)
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [IN_W-1:0]  ld_data,
    input  logic             ld_clear,
    input  logic             start,
    input  logic [CW-1:0]    num_particles,
    output logic [IN_W-1:0]  core_d_in,
    output logic             core_elem_write,
    input  logic             core_done,
    output logic             core_read_ctrl,
    input  logic             core_elem_read,
    input  logic [OUT_W-1:0] core_d_out,
    input  logic [CW-1:0]    rb_addr,
    output logic [OUT_W-1:0] rb_data,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [2:0]       state,
    output logic [31:0]      step_cnt
);
    logic [1:0]      rst_sync_q;
    logic            rst_n;
    state_t          state_q;
    logic [CW-1:0]   wr_cnt_q, n_q, idx_q;
    logic [31:0]     cnt_q, step_q;
    logic [1:0]      ph_q;
    logic            done_seen_q, we_q, rc_q, err_q, done_q;
    logic [IN_W-1:0] d_in_q, buf_rdata;
    logic            ld_acc, rb_we;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) rst_sync_q <= '0;
        else           rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    assign ld_ready = state_q == S_IDLE && !start && wr_cnt_q < CW'(DEPTH);
    assign ld_acc   = ld_valid && ld_ready;
    assign rb_we    = state_q == S_DRAIN && ph_q == 2'd1 && core_elem_read;

    // idx_q doubles as the stream read address and the readback write address
    md_sdp_ram #(.W(IN_W), .D(DEPTH), .AW(CW)) u_buf (
        .clk_i(ap_clk), .we_i(ld_acc), .waddr_i(ld_clear ? '0 : wr_cnt_q),
        .wdata_i(ld_data), .raddr_i(idx_q), .rdata_o(buf_rdata)
    );
    md_sdp_ram #(.W(OUT_W), .D(DEPTH), .AW(CW)) u_rb (
        .clk_i(ap_clk), .we_i(rb_we), .waddr_i(idx_q),
        .wdata_i(core_d_out), .raddr_i(rb_addr), .rdata_o(rb_data)
    );

    always_ff @(posedge ap_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wr_cnt_q    <= '0;
            n_q         <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            step_q      <= '0;
            ph_q        <= '0;
            done_seen_q <= 1'b0;
            we_q        <= 1'b0;
            rc_q        <= 1'b0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            d_in_q      <= '0;
        end else begin
            we_q   <= 1'b0;
            rc_q   <= 1'b0;
            err_q  <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (ld_clear)    wr_cnt_q <= ld_acc ? CW'(1) : '0;
                    else if (ld_acc) wr_cnt_q <= wr_cnt_q + 1'b1;
                    idx_q <= '0;
                    cnt_q <= '0;
                    if (start) begin
                        n_q <= num_particles;
                        if (num_particles == '0 || num_particles > wr_cnt_q) err_q <= 1'b1;
                        else begin
                            state_q     <= S_STREAM;
                            done_seen_q <= 1'b0;
                        end
                    end
                end
                // slot of WR_GAP+1 cycles: load data at 0, pulse at 2; one extra slot closes the final gap
                S_STREAM: begin
                    if (core_done) done_seen_q <= 1'b1;
                    cnt_q <= (cnt_q == 32'(WR_GAP)) ? '0 : cnt_q + 1;
                    if (idx_q < n_q) begin
                        if (cnt_q == '0) d_in_q <= buf_rdata;
                        if (cnt_q == 32'd1) begin
                            we_q  <= 1'b1;
                            idx_q <= idx_q + 1'b1;
                        end
                    end else if (cnt_q == 32'd1) begin
                        state_q <= S_WAIT;
                        cnt_q   <= '0;
                    end
                end
                S_WAIT: begin
                    if (core_done || done_seen_q) begin
                        state_q <= S_DRAIN;
                        idx_q   <= '0;
                        ph_q    <= 2'd0;
                        cnt_q   <= '0;
                    end else if (cnt_q == 32'(TIMEOUT - 1)) begin
                        err_q   <= 1'b1;
                        state_q <= S_IDLE;
                        idx_q   <= '0;
                    end else cnt_q <= cnt_q + 1;
                end
                S_DRAIN: begin
                    if (ph_q == 2'd0) begin
                        rc_q  <= 1'b1;
                        ph_q  <= 2'd1;
                        cnt_q <= '0;
                    end else if (ph_q == 2'd1) begin
                        if (core_elem_read) begin
                            ph_q  <= 2'd2;
                            cnt_q <= '0;
                        end else if (cnt_q == 32'(TIMEOUT - 1)) begin
                            err_q   <= 1'b1;
                            state_q <= S_IDLE;
                            idx_q   <= '0;
                            ph_q    <= 2'd0;
                        end else cnt_q <= cnt_q + 1;
                    end else if (cnt_q == 32'(WR_GAP - 1)) begin
                        ph_q <= 2'd0;
                        if (idx_q == n_q - 1'b1) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else idx_q <= idx_q + 1'b1;
                    end else cnt_q <= cnt_q + 1;
                end
                S_DONE: begin
                    step_q  <= step_q + 1;
                    state_q <= S_IDLE;
                    idx_q   <= '0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign core_d_in       = d_in_q;
    assign core_elem_write = we_q;
    assign core_read_ctrl  = rc_q;
    assign busy            = state_q != S_IDLE;
    assign done            = done_q;
    assign err             = err_q;
    assign state           = state_q;
    assign step_cnt        = step_q;
endmodule

// File: tb/tb_particle_io_sequencer.sv
// tb_particle_io_sequencer: directed bench with a reactive core model for particle_io_sequencer.
module tb_particle_io_sequencer;
    localparam int IN_W = 256, OUT_W = 192, DEPTH = 300, WR_GAP = 4, TIMEOUT = 1000;
    localparam int CW = $clog2(DEPTH + 1);

    logic clk = 1'b0, ap_rst_n = 1'b1;
    logic ld_valid = 1'b0, ld_clear = 1'b0, start = 1'b0;
    logic [IN_W-1:0] ld_data = '0;
    logic [CW-1:0] num_particles = '0, rb_addr = '0;
    logic core_done = 1'b0, core_elem_read = 1'b0;
    logic [OUT_W-1:0] core_d_out = '0;
    logic ld_ready, core_elem_write, core_read_ctrl, busy, done, err;
    logic [IN_W-1:0] core_d_in;
    logic [OUT_W-1:0] rb_data;
    logic [2:0] state;
    logic [31:0] step_cnt;

    particle_io_sequencer #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .WR_GAP(WR_GAP), .TIMEOUT(TIMEOUT)) dut (
        .ap_clk(clk), .ap_rst_n(ap_rst_n), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
        .ld_clear(ld_clear), .start(start), .num_particles(num_particles), .core_d_in(core_d_in),
        .core_elem_write(core_elem_write), .core_done(core_done), .core_read_ctrl(core_read_ctrl),
        .core_elem_read(core_elem_read), .core_d_out(core_d_out), .rb_addr(rb_addr), .rb_data(rb_data),
        .busy(busy), .done(done), .err(err), .state(state), .step_cnt(step_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0, n_bad = 0;
    int wr_idx = 0, first_wr = 0, last_wr = 0, stream_bad = 0, stable_bad = 0, gap_bad = 0;
    int err_total = 0, err_cyc = 0, done_total = 0, wait_cyc = 0, rc_total = 0, rd_idx = 0, ans = 0;
    int n_exp = 0, exp_seed = 0, start_cyc = 0;
    bit done_en = 1'b0;
    logic [IN_W-1:0] prev_d = '0;
    logic [2:0] prev_state = '0;

    function automatic logic [IN_W-1:0] pat(input int i, input int s);
        return {32'(s), 32'(i), 192'(i) * 192'd1000003 + 192'(s)};
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Monitor plus core model: answers each read request 5 cycles later, raises core_done 100 cycles after the last write
    always @(negedge clk) begin
        if (core_elem_write) begin
            if (core_d_in !== pat(wr_idx, exp_seed)) stream_bad++;
            if (core_d_in !== prev_d) stable_bad++;
            if (wr_idx > 0 && cyc - last_wr != WR_GAP + 1) gap_bad++;
            if (wr_idx == 0) first_wr = cyc;
            last_wr = cyc;
            wr_idx++;
        end
        prev_d = core_d_in;
        if (err) begin err_total++; err_cyc = cyc; end
        if (done) done_total++;
        if (state == 3'd2 && prev_state != 3'd2) wait_cyc = cyc;
        prev_state = state;
        core_done = done_en && n_exp > 0 && wr_idx == n_exp && cyc == last_wr + 100;
        core_elem_read = 1'b0;
        if (ans > 0) begin
            ans--;
            if (ans == 0) begin
                core_elem_read = 1'b1;
                core_d_out = OUT_W'(rd_idx);
                rd_idx++;
            end
        end
        if (core_read_ctrl) begin ans = 5; rc_total++; end
    end

    task automatic arm(input int n, input int s, input bit de);
        n_exp = n; exp_seed = s; done_en = de; wr_idx = 0; rd_idx = 0; ans = 0;
        rc_total = 0; stream_bad = 0; stable_bad = 0; gap_bad = 0;
    endtask

    task automatic load(input int n, input int s);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ld_valid = 1'b1; ld_clear = (i == 0); ld_data = pat(i, s);
        end
        @(negedge clk);
        ld_valid = 1'b0; ld_clear = 1'b0;
    endtask

    task automatic do_start(input int n);
        @(negedge clk);
        start = 1'b1; num_particles = CW'(n); start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0, k;
        d0 = done_total; k = 0;
        while (done_total == d0 && k < budget) begin @(negedge clk); k++; end
        check("done_reached", done_total - d0, 1);
    endtask

    task automatic check_run(input int steps);
        check("wr_count", wr_idx, 300);
        check("stream_data", stream_bad, 0);
        check("stream_stable", stable_bad, 0);
        check("stream_gap", gap_bad, 0);
        check("final_gap", wait_cyc - last_wr, WR_GAP + 1);
        check("start_latency", int'(first_wr - start_cyc >= 1 && first_wr - start_cyc <= 3), 1);
        check("rc_count", rc_total, 300);
        check("step_cnt", int'(step_cnt), steps);
        check("idle_after", int'(state), 0);
    endtask

    initial begin
        int e0, d0, bad, k;
        #2 ap_rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_state", int'(state), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_pulses", int'({err, done, core_elem_write, core_read_ctrl}), 0);
        check("rst_d_in", int'(core_d_in != '0), 0);
        check("rst_step", int'(step_cnt), 0);
        ap_rst_n = 1'b1;
        repeat (4) @(negedge clk);

        load(10, 1);
        check("ld_ready_partial", int'(ld_ready), 1);
        arm(0, 1, 1'b0);
        e0 = err_total;
        do_start(11);
        repeat (4) @(negedge clk);
        check("err_n_gt_cnt", err_total - e0, 1);
        check("err_no_write", wr_idx, 0);
        check("err_state", int'(state), 0);
        do_start(0);
        repeat (4) @(negedge clk);
        check("err_n_zero", err_total - e0, 2);

        load(300, 2);
        check("ld_ready_full", int'(ld_ready), 0);
        arm(300, 2, 1'b1);
        e0 = err_total; d0 = done_total;
        do_start(300);
        wait_done(20000);
        repeat (5) @(negedge clk);
        check_run(1);
        check("run1_no_err", err_total - e0, 0);
        check("run1_one_done", done_total - d0, 1);
        bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk); rb_addr = CW'(i);
            @(negedge clk); if (rb_data !== OUT_W'(i)) bad++;
        end
        check("rb_contents", bad, 0);
        @(negedge clk); rb_addr = CW'(DEPTH);
        @(negedge clk);
        check("rb_oob_zero", int'(rb_data != '0), 0);

        arm(300, 2, 1'b1);
        e0 = err_total; d0 = done_total;
        do_start(300);
        repeat (50) @(negedge clk);
        start = 1'b1; num_particles = CW'(5);
        @(negedge clk);
        start = 1'b0;
        wait_done(20000);
        repeat (5) @(negedge clk);
        check_run(2);
        check("busy_start_no_err", err_total - e0, 0);
        check("run2_one_done", done_total - d0, 1);

        arm(300, 2, 1'b0);
        e0 = err_total;
        do_start(300);
        k = 0;
        while (err_total == e0 && k < 5000) begin @(negedge clk); k++; end
        check("timeout_err", err_total - e0, 1);
        check("timeout_delay", err_cyc - wait_cyc, TIMEOUT);
        repeat (2) @(negedge clk);
        check("timeout_idle", int'(state), 0);
        check("timeout_no_drain", rc_total, 0);
        check("timeout_step", int'(step_cnt), 2);

        arm(300, 2, 1'b1);
        do_start(300);
        k = 0;
        while (rd_idx < 50 && k < 10000) begin @(negedge clk); k++; end
        check("drain_reached", int'(rd_idx >= 50), 1);
        check("drain_state", int'(state), 3);
        @(negedge clk);
        ap_rst_n = 1'b0;
        #1;
        check("arst_state", int'(state), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_pulses", int'({err, done, core_elem_write, core_read_ctrl}), 0);
        check("arst_d_in", int'(core_d_in != '0), 0);
        check("arst_step", int'(step_cnt), 0);
        repeat (3) @(negedge clk);
        ap_rst_n = 1'b1;
        repeat (4) @(negedge clk);
        arm(0, 2, 1'b0);
        e0 = err_total;
        do_start(10);
        repeat (4) @(negedge clk);
        check("reload_needed_err", err_total - e0, 1);
        check("reload_no_write", wr_idx, 0);
        check("reload_state", int'(state), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule

// File: doc/particle_io_sequencer.md
PARTICLE_IO_SEQUENCER -- requirements
Module: particle_io_sequencer

Interface
REQ-001 SHALL have parameter IN_W, default 256, particle record width into the MD core.
REQ-002 SHALL have parameter OUT_W, default 192, result record width from the MD core.
REQ-003 SHALL have parameter DEPTH, default 300, particle buffer and readback buffer depth.
REQ-004 SHALL have parameter WR_GAP, default 4, idle cycles between elem_write pulses.
REQ-005 SHALL have parameter TIMEOUT, default 65536, max cycles waiting on core_done or each core_elem_read.
REQ-006 SHALL derive CW = clog2(DEPTH+1) for all count/address ports.
REQ-007 SHALL have one clock and an asynchronous active-low reset, declared in this order: ap_clk in 1, rising-edge clock; ap_rst_n in 1, asynchronous active-low reset.
REQ-008 SHALL have these ports:
- ld_valid in 1 / ld_ready out 1 / ld_data in IN_W: host particle load.
- ld_clear in 1: clear load count.
- start in 1: run pulse.
- num_particles in CW: particles per run.
- core_d_in out IN_W / core_elem_write out 1: stream to core.
- core_done in 1: core compute finished.
- core_read_ctrl out 1: result request pulse.
- core_elem_read in 1 / core_d_out in OUT_W: result valid and data.
- rb_addr in CW / rb_data out OUT_W: readback port.
- busy out 1; done out 1; err out 1; state out 3; step_cnt out 32.

Function
REQ-009 SHALL implement states IDLE(0), STREAM(1), WAIT(2), DRAIN(3), DONE(4), encoded on state.
REQ-010 SHALL have ld_ready = (state==IDLE) && !start && (wr_cnt<DEPTH); a handshake writes ld_data to buf[wr_cnt] and increments wr_cnt.
REQ-011 SHALL zero wr_cnt on ld_clear in IDLE; ld_clear outside IDLE is ignored; ld_clear and an accepted write in the same cycle -> wr_cnt=1, entry at address 0.
REQ-012 SHALL, on start in IDLE, latch N=num_particles; N==0 or N>wr_cnt -> 1-cycle err pulse, remain IDLE; else go to STREAM.
REQ-013 SHALL ignore start outside IDLE.
REQ-014 SHALL, in STREAM, drive core_d_in=buf[i] with core_elem_write high exactly 1 cycle per particle, i=0..N-1, followed by WR_GAP low cycles; core_d_in holds stable 1 cycle before and during the pulse; first pulse within 3 cycles of start.
REQ-015 SHALL enter WAIT after the final gap, and DRAIN on core_done; core_done arriving during STREAM is latched and honoured on entering WAIT.
REQ-016 SHALL, in DRAIN, for i=0..N-1: pulse core_read_ctrl 1 cycle, wait for core_elem_read, write core_d_out to rb[i], then wait WR_GAP cycles.
REQ-017 SHALL ignore core_elem_read when no request is outstanding.
REQ-018 SHALL, when TIMEOUT cycles elapse in WAIT or awaiting core_elem_read, pulse err 1 cycle and go to IDLE with the rb contents partial.
REQ-019 SHALL, in DONE, pulse done 1 cycle, increment step_cnt (wraps at 2^32), and return to IDLE.
REQ-020 SHALL retain buf and wr_cnt across runs so repeated start pulses rerun the same particle set.
REQ-021 SHALL give rb_data a 1-cycle read latency; rb_addr>=DEPTH returns 0.
REQ-022 SHALL assert busy whenever state!=IDLE.

Reset
REQ-023 SHALL, on ap_rst_n low, force: state=IDLE; wr_cnt=0; step_cnt=0; all pulse outputs, busy, core_elem_write, core_read_ctrl and err =0; core_d_in=0.
REQ-024 SHALL abort any run on reset mid-operation; buffer RAM contents are undefined after reset.
REQ-025 SHALL release reset synchronously to ap_clk through a 2-flop synchroniser on deassertion.

Structure
REQ-026 SHALL place state encodings and the default widths (256/192/300) in shared package md_pkg.
REQ-027 SHALL implement buf and rb as instances of one sub-module, md_sdp_ram: simple dual-port, 1-cycle read, parameterised width and depth.

Verification
REQ-028 Load 300 records, start with N=300 -> exactly 300 elem_write pulses, each with core_d_in==buf[i] and 4-cycle gaps.
REQ-029 Core model raises core_done 100 cycles after the last write and answers each read_ctrl after 5 cycles with data=i -> rb[0..299]==0..299, done pulse, step_cnt==1.
REQ-030 wr_cnt=10, start with N=11 -> err pulse, no elem_write, state stays 0.
REQ-031 Core never asserts core_done with TIMEOUT=1000 -> err exactly 1000 cycles after WAIT entry, state returns to IDLE.
REQ-032 Assert ap_rst_n low mid-DRAIN at i=50 -> all outputs at reset values asynchronously, and a subsequent run needs a reload.
REQ-033 Two back-to-back starts without reload -> identical streams, step_cnt==2; start asserted while busy -> no effect.
